// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared types for the EX/MEM flag stage: condition codes, NZCV flags and
// the control bundle carried into MEM.
package cpu_pkg;

   localparam int RD_W = 5;

   typedef enum logic [3:0] {
      EQ = 4'd0,  NE = 4'd1,  HS = 4'd2,  LO = 4'd3,
      MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
      HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
      GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
   } cond_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   typedef struct packed {
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic [RD_W-1:0] rd;
   } ex_mem_ctrl_t;

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX-side and MEM-side bus of the flag stage; slave is the stage itself.
interface ex_mem_flag_stage_if #(
   parameter int DATA_W = 64,
   parameter int REG_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] alu_result;
   logic              alu_c;
   logic              alu_v;
   logic              alu_n;
   logic              alu_z;
   logic              set_flags;
   logic              is_bcond;
   logic [3:0]        cond;
   logic [REG_W-1:0]  rd;
   logic              reg_write;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] store_data;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [DATA_W-1:0] out_store_data;
   logic [REG_W-1:0]  out_rd;
   logic              out_reg_write;
   logic              out_mem_read;
   logic              out_mem_write;
   logic              out_branch_taken;
   logic [3:0]        nzcv;

   modport master (
      output in_valid, alu_result, alu_c, alu_v, alu_n, alu_z, set_flags,
             is_bcond, cond, rd, reg_write, mem_read, mem_write, store_data,
             out_ready,
      input  in_ready, out_valid, out_result, out_store_data, out_rd,
             out_reg_write, out_mem_read, out_mem_write, out_branch_taken, nzcv
   );

   modport slave (
      input  in_valid, alu_result, alu_c, alu_v, alu_n, alu_z, set_flags,
             is_bcond, cond, rd, reg_write, mem_read, mem_write, store_data,
             out_ready,
      output in_ready, out_valid, out_result, out_store_data, out_rd,
             out_reg_write, out_mem_read, out_mem_write, out_branch_taken, nzcv
   );
endinterface

// File: rtl/ex_mem_flag_stage_cond_eval.sv
// Combinational B.cond resolver; shared with the CBZ/branch unit.
module cond_eval
   import cpu_pkg::*;
(
   input  nzcv_t i_nzcv,
   input  cond_e i_cond,
   output logic  o_taken
);

   logic w_ge;
   logic w_hi;
   logic w_gt;

   assign w_ge = (i_nzcv.n == i_nzcv.v);
   assign w_hi = i_nzcv.c & ~i_nzcv.z;
   assign w_gt = ~i_nzcv.z & w_ge;

   always_comb begin
      o_taken = 1'b0;
      case (i_cond)
         EQ:      o_taken = i_nzcv.z;
         NE:      o_taken = ~i_nzcv.z;
         HS:      o_taken = i_nzcv.c;
         LO:      o_taken = ~i_nzcv.c;
         MI:      o_taken = i_nzcv.n;
         PL:      o_taken = ~i_nzcv.n;
         VS:      o_taken = i_nzcv.v;
         VC:      o_taken = ~i_nzcv.v;
         HI:      o_taken = w_hi;
         LS:      o_taken = ~w_hi;
         GE:      o_taken = w_ge;
         LT:      o_taken = ~w_ge;
         GT:      o_taken = w_gt;
         LE:      o_taken = ~w_gt;
         default: o_taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register with valid/ready handshake, architectural NZCV
// ownership and registered B.cond resolution.
module ex_mem_flag_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_W  = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   ex_mem_flag_stage_if.slave  bus
);

   logic              r_valid;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_store_data;
   ex_mem_ctrl_t      r_ctrl;
   logic              r_taken;
   nzcv_t             r_nzcv;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_cond_true;
   ex_mem_ctrl_t      w_ctrl;

   assign w_in_ready = ~r_valid | bus.out_ready;
   assign w_accept   = bus.in_valid & w_in_ready;

   assign w_ctrl.reg_write = bus.reg_write;
   assign w_ctrl.mem_read  = bus.mem_read;
   assign w_ctrl.mem_write = bus.mem_write;
   assign w_ctrl.rd        = RD_W'(bus.rd);

   // Branch resolves against the committed flags, i.e. before this edge's update.
   cond_eval u_cond_eval (
      .i_nzcv  (r_nzcv),
      .i_cond  (cond_e'(bus.cond)),
      .o_taken (w_cond_true)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid      <= 1'b0;
         r_result     <= '0;
         r_store_data <= '0;
         r_ctrl       <= '0;
         r_taken      <= 1'b0;
         r_nzcv       <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_taken <= 1'b0;
         r_ctrl  <= '0;
      end else if (w_accept) begin
         r_valid      <= 1'b1;
         r_result     <= bus.alu_result;
         r_store_data <= bus.store_data;
         r_ctrl       <= w_ctrl;
         r_taken      <= bus.is_bcond & w_cond_true;
         if (bus.set_flags) begin
            r_nzcv <= '{n: bus.alu_n, z: bus.alu_z, c: bus.alu_c, v: bus.alu_v};
         end
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
         r_taken <= 1'b0;
      end
   end

   assign bus.in_ready         = w_in_ready;
   assign bus.out_valid        = r_valid;
   assign bus.out_result       = r_result;
   assign bus.out_store_data   = r_store_data;
   assign bus.out_rd           = REG_W'(r_ctrl.rd);
   assign bus.out_reg_write    = r_valid & r_ctrl.reg_write;
   assign bus.out_mem_read     = r_valid & r_ctrl.mem_read;
   assign bus.out_mem_write    = r_valid & r_ctrl.mem_write;
   assign bus.out_branch_taken = r_taken;
   assign bus.nzcv             = r_nzcv;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: back-to-back vector table plus stall,
// flush and asynchronous-reset sequences.
module tb_ex_mem_flag_stage;

   logic clk;
   logic rst_n;
   logic flush;

   ex_mem_flag_stage_if #(.DATA_W(64), .REG_W(5)) bus ();

   ex_mem_flag_stage #(.DATA_W(64), .REG_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] res;
      logic [3:0]  flg;      // {n,z,c,v} from the adder
      logic        sf;
      logic        bc;
      logic [3:0]  cond;
      logic [3:0]  exp_nzcv;
      logic        exp_taken;
   } vec_t;

   vec_t tv[24];

   task automatic set_vec(input int i, input logic [63:0] res, input logic [3:0] flg,
                          input logic sf, input logic bc, input logic [3:0] cond,
                          input logic [3:0] en, input logic et);
      tv[i].res = res; tv[i].flg = flg; tv[i].sf = sf; tv[i].bc = bc;
      tv[i].cond = cond; tv[i].exp_nzcv = en; tv[i].exp_taken = et;
   endtask

   task automatic drive(input logic [63:0] res, input logic [3:0] flg, input logic sf,
                        input logic bc, input logic [3:0] cond, input logic [4:0] rd);
      bus.in_valid   = 1'b1;
      bus.alu_result = res;
      {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = flg;
      bus.set_flags  = sf;
      bus.is_bcond   = bc;
      bus.cond       = cond;
      bus.rd         = rd;
      bus.reg_write  = rd[0];
      bus.mem_read   = rd[1];
      bus.mem_write  = rd[2];
      bus.store_data = ~res;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Hand-computed sequence; each row accepted on consecutive edges.
      set_vec( 0, 64'h0,                   4'b0100, 1, 0, 4'd0,  4'b0100, 0); // SUBS 0-0
      set_vec( 1, 64'h10,                  4'b0000, 0, 1, 4'd0,  4'b0100, 1); // B.EQ
      set_vec( 2, 64'h20,                  4'b0000, 0, 1, 4'd2,  4'b0100, 0); // B.HS
      set_vec( 3, 64'h8000_0000_0000_0000, 4'b1000, 0, 0, 4'd0,  4'b0100, 0); // ADD
      set_vec( 4, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1, 0, 4'd0,  4'b1000, 0); // SUBS N
      set_vec( 5, 64'h50,                  4'b0000, 0, 1, 4'd11, 4'b1000, 1); // B.LT
      set_vec( 6, 64'h8000_0000_0000_0001, 4'b1001, 1, 0, 4'd0,  4'b1001, 0); // SUBS N,V
      set_vec( 7, 64'h70,                  4'b0000, 0, 1, 4'd10, 4'b1001, 1); // B.GE
      set_vec( 8, 64'h0,                   4'b0100, 1, 0, 4'd0,  4'b0100, 0); // SUBS Z
      set_vec( 9, 64'h90,                  4'b0000, 0, 1, 4'd12, 4'b0100, 0); // B.GT
      set_vec(10, 64'hA0,                  4'b0000, 0, 1, 4'd13, 4'b0100, 1); // B.LE
      set_vec(11, 64'hB0,                  4'b0000, 0, 1, 4'd1,  4'b0100, 0); // B.NE
      set_vec(12, 64'hC0,                  4'b0000, 0, 1, 4'd14, 4'b0100, 1); // B.AL
      set_vec(13, 64'h5,                   4'b0010, 1, 0, 4'd0,  4'b0010, 0); // SUBS C
      set_vec(14, 64'hE0,                  4'b0000, 0, 1, 4'd8,  4'b0010, 1); // B.HI
      set_vec(15, 64'hF0,                  4'b0000, 0, 1, 4'd9,  4'b0010, 0); // B.LS
      set_vec(16, 64'h100,                 4'b0000, 0, 1, 4'd4,  4'b0010, 0); // B.MI
      set_vec(17, 64'h110,                 4'b0000, 0, 1, 4'd5,  4'b0010, 1); // B.PL
      set_vec(18, 64'h120,                 4'b0000, 0, 1, 4'd6,  4'b0010, 0); // B.VS
      set_vec(19, 64'h130,                 4'b0000, 0, 1, 4'd7,  4'b0010, 1); // B.VC
      set_vec(20, 64'h140,                 4'b0000, 0, 1, 4'd3,  4'b0010, 0); // B.LO
      set_vec(21, 64'h150,                 4'b0000, 0, 1, 4'd15, 4'b0010, 1); // cond 15
      set_vec(22, 64'h0,                   4'b0100, 1, 1, 4'd0,  4'b0100, 0); // illegal SUBS+B.EQ
      set_vec(23, 64'h170,                 4'b0000, 0, 1, 4'd0,  4'b0100, 1); // B.EQ

      rst_n = 1'b0;
      flush = 1'b0;
      bus.out_ready = 1'b1;
      drive(64'h0, 4'b0000, 0, 0, 4'd0, 5'd0);
      bus.in_valid = 1'b0;
      #12;
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_nzcv", 64'(bus.nzcv), 64'd0);
      chk("reset_taken", 64'(bus.out_branch_taken), 64'd0);
      chk("reset_result", bus.out_result, 64'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 24; i++) begin
         drive(tv[i].res, tv[i].flg, tv[i].sf, tv[i].bc, tv[i].cond, 5'(i));
         tick();
         chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
         chk($sformatf("v%0d_result", i), bus.out_result, tv[i].res);
         chk($sformatf("v%0d_store", i), bus.out_store_data, ~tv[i].res);
         chk($sformatf("v%0d_rd", i), 64'(bus.out_rd), 64'(i));
         chk($sformatf("v%0d_ctrl", i),
             64'({bus.out_mem_write, bus.out_mem_read, bus.out_reg_write}), 64'(i % 8));
         chk($sformatf("v%0d_nzcv", i), 64'(bus.nzcv), 64'(tv[i].exp_nzcv));
         chk($sformatf("v%0d_taken", i), 64'(bus.out_branch_taken), 64'(tv[i].exp_taken));
      end

      // Stall: A held while MEM backpressures, B accepted on release with no bubble.
      drive(64'hAAAA, 4'b0000, 0, 0, 4'd0, 5'd7);
      tick();
      chk("stall_a_valid", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b0;
      drive(64'hBBBB, 4'b0000, 0, 0, 4'd0, 5'd3);
      #1;
      chk("stall_in_ready_comb", 64'(bus.in_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("stall%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
         chk($sformatf("stall%0d_result", k), bus.out_result, 64'hAAAA);
         chk($sformatf("stall%0d_rd", k), 64'(bus.out_rd), 64'd7);
         chk($sformatf("stall%0d_valid", k), 64'(bus.out_valid), 64'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("release_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk("release_valid", 64'(bus.out_valid), 64'd1);
      chk("release_result", bus.out_result, 64'hBBBB);
      chk("release_rd", 64'(bus.out_rd), 64'd3);

      // Drain with nothing incoming.
      bus.in_valid = 1'b0;
      tick();
      chk("drain_valid", 64'(bus.out_valid), 64'd0);
      chk("drain_reg_write", 64'(bus.out_reg_write), 64'd0);

      // Flush against an accepting SUBS leaves NZCV untouched.
      drive(64'h9, 4'b1010, 1, 0, 4'd0, 5'd1);
      tick();
      chk("preflush_nzcv", 64'(bus.nzcv), 64'hA);
      drive(64'h0, 4'b0100, 1, 1, 4'd14, 5'd1);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_nzcv", 64'(bus.nzcv), 64'hA);
      chk("flush_taken", 64'(bus.out_branch_taken), 64'd0);
      chk("flush_reg_write", 64'(bus.out_reg_write), 64'd0);

      // Asynchronous reset mid-cycle with a held instruction and NZCV=1010.
      drive(64'h1234, 4'b0000, 0, 0, 4'd0, 5'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      chk("prerst_valid", 64'(bus.out_valid), 64'd1);
      chk("prerst_nzcv", 64'(bus.nzcv), 64'hA);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst_nzcv", 64'(bus.nzcv), 64'd0);
      chk("async_rst_reg_write", 64'(bus.out_reg_write), 64'd0);
      chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
      #2;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      chk("post_rst_valid", 64'(bus.out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
